// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//  Shares the single-port unified instruction/data memory of the multicycle
//  core between the core memory port and the program loader. Each access runs
//  IDLE -> ACCESS -> (WAIT x MEM_LAT, reads only) -> DONE -> IDLE. The core is
//  held through core_stall until its own ack. The loader normally wins a tie.
//  After STARVE_MAX consecutive loader grants against a waiting core, the core
//  is forced through.
//
//  Optional feature: define MEM_ARB_RANGE_CHECK_EN to flag core accesses that
//  are misaligned or beyond MEM_WORDS. A flagged access never reaches the
//  memory and completes with core_err. The loader is never checked.
module mem_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8,
  parameter int MEM_WORDS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  // core requester
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_err,
  output logic              core_stall,
  // loader requester
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int WAIT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [ADDR_W-3:0]   WORDS_LIM  = (ADDR_W-2)'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Transaction latched at grant; requesters may change freely afterwards.
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   core_rdata_q;
  logic [DATA_W-1:0]   ldr_rdata_q;

  logic any_req;
  logic starve_full;
  logic grant_ldr;
  logic wait_last;
  logic range_bad;

  assign any_req     = core_req | ldr_req;
  assign starve_full = (starve_cnt == STARVE_TOP);
  // Loader wins ties unless the core has been passed over STARVE_MAX times.
  assign grant_ldr   = ldr_req & ~(core_req & starve_full);
  assign wait_last   = (wait_cnt == WAIT_LAST);

`ifdef MEM_ARB_RANGE_CHECK_EN
  logic err_q;

  // Only the core is checked; the loader must be able to write anywhere.
  assign range_bad = (state == S_ACCESS) & ~owner_q &
                     ((addr_q[1:0] != 2'b00) | (addr_q[ADDR_W-1:2] >= WORDS_LIM));

  // Remember the verdict of the ACCESS cycle so DONE can report it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_ACCESS) begin
      err_q <= range_bad;
    end
  end

  assign core_err = core_ack & err_q;
`else
  // Without the check every address is forwarded, so the byte offset and the
  // depth limit have no consumer.
  logic unused_range;

  assign range_bad    = 1'b0;
  assign unused_range = ^{addr_q[1:0], WORDS_LIM};
  assign core_err     = 1'b0;
`endif

  // FSM state register; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: nonblocking (<=) so every register samples pre-edge values and
    // the order of always blocks cannot change the result.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic plus memory strobes and acks decoded from the state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_ack  = 1'b0;
    ldr_ack   = 1'b0;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // A flagged access never touches the memory; the bus stays quiet.
        if (!range_bad) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q[ADDR_W-1:2];
          mem_wdata = wdata_q;
        end
        state_d = (we_q || range_bad) ? S_DONE : S_WAIT;
      end

      S_WAIT: begin
        if (wait_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        core_ack = ~owner_q;
        ldr_ack  = owner_q;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant latching, starvation counting, read-wait timing and data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt   <= '0;
      wait_cnt     <= '0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= grant_ldr;
            we_q    <= grant_ldr ? ldr_we    : core_we;
            addr_q  <= grant_ldr ? ldr_addr  : core_addr;
            wdata_q <= grant_ldr ? ldr_wdata : core_wdata;
          end
          // Cleared when the core is served or is not waiting at all;
          // otherwise each loader grant against a waiting core counts.
          if (!core_req || !grant_ldr) begin
            starve_cnt <= '0;
          end else if (!starve_full) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end

        S_ACCESS: begin
          wait_cnt <= '0;
          if (range_bad) begin
            core_rdata_q <= '0;
          end
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          // Only the owner's register moves; the other keeps its last value.
          if (wait_last) begin
            if (owner_q) begin
              ldr_rdata_q <= mem_rdata;
            end else begin
              core_rdata_q <= mem_rdata;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign core_rdata = core_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign owner      = owner_q;
  assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
//  Bench for mem_access_arbiter. Main instance uses MEM_LAT=1. A second
//  instance uses MEM_LAT=3 for the mid-wait reset case. Completions are
//  scored against a queue of expected results built from a shadow copy of
//  memory. Honours MEM_ARB_RANGE_CHECK_EN when it is defined.
module tb_mem_access_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (MEM_LAT = 1)
  logic        core_req, core_we, core_ack, core_err, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        ldr_req, ldr_we, ldr_ack;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_en, mem_we, owner;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // second instance (MEM_LAT = 3)
  logic        c3_req, c3_we, c3_ack, c3_err, c3_stall;
  logic [31:0] c3_addr, c3_wdata, c3_rdata;
  logic        l3_req, l3_we, l3_ack;
  logic [31:0] l3_addr, l3_wdata, l3_rdata;
  logic        m3_en, m3_we, owner3;
  logic [29:0] m3_addr;
  logic [31:0] m3_wdata, m3_rdata;

  mem_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_MAX(8), .MEM_WORDS(64)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(3), .STARVE_MAX(8), .MEM_WORDS(64)
  ) dut3 (
    .clk(clk), .rst(rst),
    .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wdata),
    .core_rdata(c3_rdata), .core_ack(c3_ack), .core_err(c3_err), .core_stall(c3_stall),
    .ldr_req(l3_req), .ldr_we(l3_we), .ldr_addr(l3_addr), .ldr_wdata(l3_wdata),
    .ldr_rdata(l3_rdata), .ldr_ack(l3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .owner(owner3)
  );

  // ---------------------------------------------------------------- memories
  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
  endfunction

  logic [31:0] tb_mem  [256];
  logic [31:0] tb_mem3 [16];
  logic [31:0] exp_mem [256];
  bit          mem_ready = 1'b0;
  logic [31:0] p1, p2;

  // Read data is valid exactly MEM_LAT cycles after the mem_en cycle, zero otherwise.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
      for (int i = 0; i < 16; i++) tb_mem3[i] <= 32'h3300_0000 + 32'(i);
      mem_ready <= 1'b1;
      mem_rdata <= '0;
      p1 <= '0; p2 <= '0; m3_rdata <= '0;
    end else begin
      if (mem_en && mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= (mem_en && !mem_we) ? tb_mem[mem_addr[7:0]] : '0;
      if (m3_en && m3_we) tb_mem3[m3_addr[3:0]] <= m3_wdata;
      p1       <= (m3_en && !m3_we) ? tb_mem3[m3_addr[3:0]] : '0;
      p2       <= p1;
      m3_rdata <= p2;
    end
  end

  // -------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic        owner;
    logic        chk_data;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Expected completion in grant order; writes update the shadow memory.
  function automatic void push_exp(input bit own, input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input bit err);
    exp_t e;
    e.owner    = own;
    e.err      = err;
    e.chk_data = !we || err;
    e.data     = '0;
    if (!err) begin
      if (we) exp_mem[addr[9:2]] = wdata;
      else    e.data = exp_mem[addr[9:2]];
    end
    sb_q.push_back(e);
  endfunction

  // Completion monitor plus the idle-bus rule, sampled away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_en) check("bus_quiet", {mem_we, mem_addr, mem_wdata}, '0);
      if (core_ack || ldr_ack) begin
        check("ack_excl", core_ack & ldr_ack, 1'b0);
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 1'b1, 1'b0);
        end else begin
          sb_e = sb_q.pop_front();
          check("ack_owner", ldr_ack, sb_e.owner);
          check("owner_out", owner, sb_e.owner);
          check("core_err", core_err, sb_e.err);
          if (sb_e.chk_data) begin
            if (sb_e.owner) check("ldr_rdata", ldr_rdata, sb_e.data);
            else            check("core_rdata", core_rdata, sb_e.data);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------ tasks
  task automatic do_txn(input bit is_ldr, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit err, input int drop_cyc,
                        output int lat, output int en_cyc, output logic [29:0] en_addr,
                        output int stall_bad);
    bit ack;
    lat = -1; en_cyc = -1; en_addr = '0; stall_bad = 0;
    @(posedge clk); #1;
    if (is_ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    push_exp(is_ldr, we, addr, wdata, err);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ack = is_ldr ? ldr_ack : core_ack;
      if (mem_en && en_cyc < 0) begin
        en_cyc  = c;
        en_addr = mem_addr;
      end
      if (ack) begin
        lat = c;
        break;
      end
      if (!is_ldr && core_req && !core_stall) stall_bad++;
      @(posedge clk); #1;
      if (c + 1 == drop_cyc) begin
        core_req = 1'b0; ldr_req = 1'b0;
        core_addr = 32'hFFFF_FFF0; core_wdata = 32'h0BAD_0BAD;
      end
    end
    @(posedge clk); #1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
  endtask

  task automatic do_txn3(input logic [31:0] addr, output int lat, output logic [31:0] rd);
    lat = -1; rd = '0;
    @(posedge clk); #1;
    c3_req = 1'b1; c3_addr = addr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c3_ack) begin
        lat = c;
        rd  = c3_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    c3_req = 1'b0;
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    int          lat, en_c, sb, l_at, c_at, stall_bad, l_before, l_after, n_ack3;
    logic [29:0] en_a;
    logic [31:0] rd;
    bit          la, ca, c_done, fin, is_l, we;
    int          w;
    logic [31:0] d;

    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ldr_req  = 0; ldr_we  = 0; ldr_addr  = '0; ldr_wdata  = '0;
    c3_req = 0; c3_we = 0; c3_addr = '0; c3_wdata = '0;
    l3_req = 0; l3_we = 0; l3_addr = '0; l3_wdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_acks", {core_ack, ldr_ack, core_err, core_stall}, '0);
    check("rst_bus", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check("rst_owner", owner, 1'b0);
    check("rst_core_rdata", core_rdata, '0);
    check("rst_ldr_rdata", ldr_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // core read of 0x10: mem_en cycle 1 at word 4, ack cycle 3
    do_txn(0, 0, 32'h10, '0, 0, -1, lat, en_c, en_a, sb);
    check("t1_lat", lat, 3);
    check("t1_en_cyc", en_c, 1);
    check("t1_en_addr", en_a, 30'd4);
    check("t1_stall", sb, 0);
    check("t1_rdata", core_rdata, 32'hDEAD_BEEF);

    // loader read sets ldr_rdata for the hold check below
    do_txn(1, 0, 32'h14, '0, 0, -1, lat, en_c, en_a, sb);
    check("ldr_rd_lat", lat, 3);
    check("ldr_rd_data", ldr_rdata, 32'hA500_0005);

    // simultaneous loader write and core read of the same word
    @(posedge clk); #1;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h8; ldr_wdata = 32'h1234_5678;
    core_req = 1; core_we = 0; core_addr = 32'h8;
    push_exp(1, 1, 32'h8, 32'h1234_5678, 0);
    push_exp(0, 0, 32'h8, '0, 0);
    l_at = -1; c_at = -1; stall_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      la = ldr_ack; ca = core_ack;
      if (la) l_at = c;
      if (ca) c_at = c;
      if (core_req && !ca && !core_stall) stall_bad++;
      @(posedge clk); #1;
      if (la) ldr_req = 0;
      if (ca) begin
        core_req = 0;
        break;
      end
    end
    ldr_req = 0; core_req = 0; ldr_we = 0;
    check("t2_ldr_ack_cyc", l_at, 2);
    check("t2_core_ack_cyc", c_at, 6);
    check("t2_stall", stall_bad, 0);
    check("t2_core_rdata", core_rdata, 32'h1234_5678);
    check("t2_ldr_rdata_hold", ldr_rdata, 32'hA500_0005);

    // starvation: 8 loader grants, then the core, then the loader again
    @(posedge clk); #1;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'hCAFE_0000;
    core_req = 1; core_we = 0; core_addr = 32'h20;
    for (int i = 0; i < 8; i++) push_exp(1, 1, 32'h20, 32'hCAFE_0000, 0);
    push_exp(0, 0, 32'h20, '0, 0);
    for (int i = 0; i < 2; i++) push_exp(1, 1, 32'h20, 32'hCAFE_0000, 0);
    l_before = 0; l_after = 0; c_done = 0; fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      la = ldr_ack; ca = core_ack;
      if (ca) c_done = 1;
      if (la) begin
        if (c_done) l_after++;
        else        l_before++;
      end
      @(posedge clk); #1;
      if (ca) core_req = 0;
      if (la && l_after == 2) begin
        ldr_req = 0;
        fin = 1;
      end
    end
    ldr_req = 0; core_req = 0; ldr_we = 0;
    check("t3_ldr_before", l_before, 8);
    check("t3_core_done", c_done, 1'b1);
    check("t3_ldr_after", l_after, 2);

    // MEM_LAT=3 instance: normal read, then reset in the 2nd WAIT cycle
    do_txn3(32'h8, lat, rd);
    check("t4_pre_lat", lat, 5);
    check("t4_pre_rdata", rd, 32'h3300_0002);
    @(posedge clk); #1;
    c3_req = 1; c3_addr = 32'hC;
    @(negedge clk);
    @(negedge clk);
    check("t4_access", {m3_en, m3_addr}, {1'b1, 30'd3});
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; c3_req = 0;
    #1;
    check("t4_rst_acks", {c3_ack, c3_err, c3_stall, l3_ack, owner3}, '0);
    check("t4_rst_bus", {m3_en, m3_we, m3_addr, m3_wdata}, '0);
    check("t4_rst_rdata", {c3_rdata, l3_rdata}, '0);
    check("t4_rst_main_ldr_rdata", ldr_rdata, '0);
    @(negedge clk);
    rst = 1'b0;
    n_ack3 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c3_ack) n_ack3++;
    end
    check("t4_no_ack", n_ack3, 0);
    do_txn3(32'hC, lat, rd);
    check("t4_post_lat", lat, 5);
    check("t4_post_rdata", rd, 32'h3300_0003);

    // range check on core address 0x100 (word 64 of 64)
`ifdef MEM_ARB_RANGE_CHECK_EN
    do_txn(0, 0, 32'h100, '0, 1, -1, lat, en_c, en_a, sb);
    check("t5_lat", lat, 2);
    check("t5_no_mem_en", en_c, -1);
    check("t5_rdata", core_rdata, '0);
    do_txn(0, 1, 32'h6, 32'h1111_1111, 1, -1, lat, en_c, en_a, sb);
    check("t5_mis_lat", lat, 2);
    check("t5_mis_no_mem_en", en_c, -1);
    do_txn(1, 1, 32'h100, 32'h7777_0000, 0, -1, lat, en_c, en_a, sb);
    check("t5_ldr_lat", lat, 2);
    check("t5_ldr_en_addr", en_a, 30'd64);
`else
    do_txn(0, 0, 32'h100, '0, 0, -1, lat, en_c, en_a, sb);
    check("t5_lat", lat, 3);
    check("t5_en_cyc", en_c, 1);
    check("t5_en_addr", en_a, 30'd64);
`endif

    // core drops req in the ACCESS cycle of a write
    do_txn(0, 1, 32'h30, 32'h5A5A_A5A5, 0, 1, lat, en_c, en_a, sb);
    check("t6_lat", lat, 2);
    check("t6_en_addr", en_a, 30'd12);
    check("t6_committed", tb_mem[12], 32'h5A5A_A5A5);
    do_txn(0, 0, 32'h30, '0, 0, -1, lat, en_c, en_a, sb);
    check("t6_readback_lat", lat, 3);

    // mixed single transactions
    for (int i = 0; i < 8; i++) begin
      is_l = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      w    = $urandom_range(0, 63);
      d    = $urandom;
      do_txn(is_l, we, 32'(w) << 2, d, 0, -1, lat, en_c, en_a, sb);
      check("mix_lat", lat, we ? 2 : 3);
      check("mix_en_addr", en_a, 30'(w));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
